// File: rtl/pic_pkg.sv
// Shared encodings for the PIC bus initiator: address line meaning, control-word
// bit positions and the state encodings of the bus cycle and init sequencer.
package pic_pkg;

    localparam logic A0_CMD  = 1'b0;
    localparam logic A0_DATA = 1'b1;

    localparam logic [2:0] ICW1_IC4  = 3'd0;
    localparam logic [2:0] ICW1_SNGL = 3'd1;
    localparam logic [2:0] ICW1_TAG  = 3'd4;
    localparam logic [2:0] OCW_TAG3  = 3'd3;
    localparam logic [2:0] OCW_TAG4  = 3'd4;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        BUS_IDLE   = 3'd0,
        BUS_SETUP  = 3'd1,
        BUS_STROBE = 3'd2,
        BUS_HOLD   = 3'd3,
        BUS_RECOV  = 3'd4
    } bus_state_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ICW1 = 3'd1,
        S_ICW2 = 3'd2,
        S_ICW3 = 3'd3,
        S_ICW4 = 3'd4,
        S_OCW1 = 3'd5,
        S_DONE = 3'd6
    } seq_state_t;

    function automatic logic [7:0] force_bit(input logic [7:0] d, input logic [2:0] pos,
                                             input logic val);
        logic [7:0] r;
        r      = d;
        r[pos] = val;
        return r;
    endfunction

endpackage

// File: rtl/pic_bus_cycle.sv
// One timed PIC bus cycle: SETUP, STROBE, HOLD, RECOV. Pin outputs are registered
// from the next state so they change together with the state register.
module pic_bus_cycle
    import pic_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int RECOV_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       rd,
    input  logic       a0,
    input  logic [7:0] data,
    input  logic [7:0] d_in,
    output logic       done,
    output logic       idle,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       addr,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic [7:0] cap_data,
    output logic       cap_valid
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] RECOV_LAST = CNT_W'(RECOV_CYC - 1);

    bus_state_t       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             load_s, done_s, rd_sel_s, drive_s, capture_s;
    logic             cyc_rd_r, cs_n_r, wr_n_r, rd_n_r, addr_r, d_oe_r, cap_valid_r;
    logic [7:0]       d_out_r, cap_data_r;

    // Next-state sequencing; a go on the last RECOV cycle chains straight into SETUP
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        load_s  = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            BUS_IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                if (go) begin
                    state_s = BUS_SETUP;
                    load_s  = 1'b1;
                end else begin
                    state_s = BUS_IDLE;
                end
            end
            BUS_SETUP: begin
                if (cnt_r == SETUP_LAST) begin
                    state_s = BUS_STROBE;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = BUS_SETUP;
                end
            end
            BUS_STROBE: begin
                if (cnt_r == PULSE_LAST) begin
                    state_s = BUS_HOLD;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = BUS_STROBE;
                end
            end
            BUS_HOLD: begin
                state_s = BUS_RECOV;
                cnt_s   = {CNT_W{1'b0}};
            end
            BUS_RECOV: begin
                if (cnt_r == RECOV_LAST) begin
                    done_s = 1'b1;
                    cnt_s  = {CNT_W{1'b0}};
                    if (go) begin
                        state_s = BUS_SETUP;
                        load_s  = 1'b1;
                    end else begin
                        state_s = BUS_IDLE;
                    end
                end else begin
                    state_s = BUS_RECOV;
                end
            end
            default: begin
                state_s = BUS_IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
        rd_sel_s  = load_s ? rd : cyc_rd_r;
        drive_s   = (state_s == BUS_SETUP) || (state_s == BUS_STROBE) || (state_s == BUS_HOLD);
        capture_s = (state_r == BUS_STROBE) && (state_s == BUS_HOLD) && cyc_rd_r;
    end

    // State, latched cycle attributes and registered pin drivers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= BUS_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            cyc_rd_r    <= 1'b0;
            cs_n_r      <= 1'b1;
            wr_n_r      <= 1'b1;
            rd_n_r      <= 1'b1;
            addr_r      <= 1'b0;
            d_out_r     <= 8'h00;
            d_oe_r      <= 1'b0;
            cap_data_r  <= 8'h00;
            cap_valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (load_s) begin
                cyc_rd_r <= rd;
                addr_r   <= a0;
                d_out_r  <= data;
            end
            cs_n_r      <= ~drive_s;
            wr_n_r      <= ~((state_s == BUS_STROBE) && !rd_sel_s);
            rd_n_r      <= ~((state_s == BUS_STROBE) && rd_sel_s);
            d_oe_r      <= drive_s && !rd_sel_s;
            cap_valid_r <= capture_s;
            if (capture_s) begin
                cap_data_r <= d_in;
            end
        end
    end

    assign done      = done_s;
    assign idle      = (state_r == BUS_IDLE);
    assign cs_n      = cs_n_r;
    assign wr_n      = wr_n_r;
    assign rd_n      = rd_n_r;
    assign addr      = addr_r;
    assign d_out     = d_out_r;
    assign d_oe      = d_oe_r;
    assign cap_data  = cap_data_r;
    assign cap_valid = cap_valid_r;

endmodule

// File: rtl/pic_bus_initiator.sv
// PIC bus master: runs the ICW1..ICW4 + OCW1 init sequence on start, then serves
// single OCW writes and register reads from the local controller.
module pic_bus_initiator
    import pic_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int RECOV_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    input  logic [7:0] ocw1_mask,
    input  logic       req_valid,
    input  logic       req_rd,
    input  logic       req_a0,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       CS_n,
    output logic       WR_n,
    output logic       RD_n,
    output logic       A0,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic [7:0] D_in,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       init_done
);

    seq_state_t seq_r, seq_s;
    logic [7:0] icw1_r, icw2_r, icw3_r, icw4_r, mask_r;
    logic       init_done_r, init_done_s, busy_r, busy_s;
    logic       bus_idle_s, bus_done_s, seq_active_s;
    logic       start_acc_s, req_acc_s, latch_s;
    logic       go_s, go_rd_s, go_a0_s;
    logic [7:0] go_data_s;

    // ICW3 only for cascade mode, ICW4 only when ICW1 asks for it
    function automatic seq_state_t next_step(input seq_state_t cur, input logic [7:0] w1);
        case (cur)
            S_ICW1:  return S_ICW2;
            S_ICW2:  return !w1[ICW1_SNGL] ? S_ICW3 : (w1[ICW1_IC4] ? S_ICW4 : S_OCW1);
            S_ICW3:  return w1[ICW1_IC4] ? S_ICW4 : S_OCW1;
            S_ICW4:  return S_OCW1;
            default: return S_OCW1;
        endcase
    endfunction

    assign seq_active_s = (seq_r == S_ICW1) || (seq_r == S_ICW2) || (seq_r == S_ICW3) ||
                          (seq_r == S_ICW4) || (seq_r == S_OCW1);
    assign req_ready    = bus_idle_s && init_done_r && !start;

    // Arbitration between init start, next init step and controller requests
    always_comb begin
        seq_s       = seq_r;
        init_done_s = init_done_r;
        latch_s     = 1'b0;
        go_s        = 1'b0;
        go_rd_s     = 1'b0;
        go_a0_s     = A0_CMD;
        go_data_s   = 8'h00;
        start_acc_s = start && bus_idle_s && !seq_active_s;
        req_acc_s   = req_valid && req_ready;
        if (start_acc_s) begin
            latch_s     = 1'b1;
            init_done_s = 1'b0;
            seq_s       = S_ICW1;
            go_s        = 1'b1;
            go_data_s   = force_bit(icw1, ICW1_TAG, 1'b1);
        end else if (bus_done_s && seq_active_s) begin
            if (seq_r == S_OCW1) begin
                seq_s       = S_DONE;
                init_done_s = 1'b1;
            end else begin
                seq_s   = next_step(seq_r, icw1_r);
                go_s    = 1'b1;
                go_a0_s = A0_DATA;
                case (seq_s)
                    S_ICW2:  go_data_s = icw2_r;
                    S_ICW3:  go_data_s = icw3_r;
                    S_ICW4:  go_data_s = icw4_r;
                    S_OCW1:  go_data_s = mask_r;
                    default: go_data_s = 8'h00;
                endcase
            end
        end else if (req_acc_s) begin
            go_s      = 1'b1;
            go_rd_s   = req_rd;
            go_a0_s   = req_a0;
            // Command-port writes keep bit4 clear so the PIC never sees a stray ICW1
            go_data_s = (req_a0 == A0_CMD) ? force_bit(req_data, OCW_TAG4, 1'b0) : req_data;
        end else begin
            go_s = 1'b0;
        end
        busy_s = (seq_s != S_IDLE && seq_s != S_DONE) || go_s || (!bus_idle_s && !bus_done_s);
    end

    // Sequencer state, latched init bytes and registered status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_r       <= S_IDLE;
            icw1_r      <= 8'h00;
            icw2_r      <= 8'h00;
            icw3_r      <= 8'h00;
            icw4_r      <= 8'h00;
            mask_r      <= 8'h00;
            init_done_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            seq_r       <= seq_s;
            init_done_r <= init_done_s;
            busy_r      <= busy_s;
            if (latch_s) begin
                icw1_r <= icw1;
                icw2_r <= icw2;
                icw3_r <= icw3;
                icw4_r <= icw4;
                mask_r <= ocw1_mask;
            end
        end
    end

    pic_bus_cycle #(
        .SETUP_CYC(SETUP_CYC),
        .PULSE_CYC(PULSE_CYC),
        .RECOV_CYC(RECOV_CYC)
    ) u_cycle (
        .clk      (clk),
        .rst      (rst),
        .go       (go_s),
        .rd       (go_rd_s),
        .a0       (go_a0_s),
        .data     (go_data_s),
        .d_in     (D_in),
        .done     (bus_done_s),
        .idle     (bus_idle_s),
        .cs_n     (CS_n),
        .wr_n     (WR_n),
        .rd_n     (RD_n),
        .addr     (A0),
        .d_out    (D_out),
        .d_oe     (D_oe),
        .cap_data (rd_data),
        .cap_valid(rd_valid)
    );

    assign busy      = busy_r;
    assign init_done = init_done_r;

endmodule

// File: tb/tb_pic_bus_initiator.sv
// Directed bench for pic_bus_initiator: init sequences, request cycles, start
// arbitration and asynchronous reset in the middle of a bus cycle.
module tb_pic_bus_initiator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] icw1 = 8'h00, icw2 = 8'h00, icw3 = 8'h00, icw4 = 8'h00, ocw1_mask = 8'h00;
    logic       req_valid = 1'b0, req_rd = 1'b0, req_a0 = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, CS_n, WR_n, RD_n, A0, D_oe, rd_valid, busy, init_done;
    logic [7:0] D_out, D_in, rd_data;

    int chk_cnt = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    // Simple PIC model: drives a fixed status byte while RD_n is low
    assign D_in = !RD_n ? 8'h5C : 8'h00;

    pic_bus_initiator dut (
        .clk(clk), .rst(rst), .start(start),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1_mask(ocw1_mask),
        .req_valid(req_valid), .req_rd(req_rd), .req_a0(req_a0), .req_data(req_data),
        .req_ready(req_ready), .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n), .A0(A0),
        .D_out(D_out), .D_oe(D_oe), .D_in(D_in), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .init_done(init_done)
    );

    // Pin monitor: logs every write strobe and measures strobe/select widths
    int         wr_pulses = 0, rd_pulses = 0, rdv_pulses = 0, oe_cycles = 0, recov_oe = 0;
    int         wr_len = 0, cs_len = 0, rd_len = 0;
    int         last_wr_len = 0, last_cs_len = 0, last_rd_len = 0;
    logic       wr_q = 1'b1, cs_q = 1'b1, rd_q = 1'b1;
    logic [7:0] rdv_data = 8'h00;
    logic [8:0] wr_log [0:63];

    always @(negedge clk) begin
        if (!WR_n && wr_q) begin
            wr_log[wr_pulses[5:0]] <= {A0, D_out};
            wr_pulses <= wr_pulses + 1;
        end
        if (!RD_n && rd_q) rd_pulses <= rd_pulses + 1;
        if (!WR_n) wr_len <= wr_len + 1;
        else if (!wr_q) begin last_wr_len <= wr_len; wr_len <= 0; end
        if (!RD_n) rd_len <= rd_len + 1;
        else if (!rd_q) begin last_rd_len <= rd_len; rd_len <= 0; end
        if (!CS_n) cs_len <= cs_len + 1;
        else if (!cs_q) begin last_cs_len <= cs_len; cs_len <= 0; end
        if (rd_valid) begin rdv_pulses <= rdv_pulses + 1; rdv_data <= rd_data; end
        if (D_oe) oe_cycles <= oe_cycles + 1;
        if (D_oe && CS_n) recov_oe <= recov_oe + 1;
        wr_q <= WR_n;
        rd_q <= RD_n;
        cs_q <= CS_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    int base_wr;

    // Pulse start (optionally with a request), then count cycles until init_done
    task automatic run_init(input string tag, input logic [7:0] i1, input logic [7:0] i2,
                            input logic [7:0] i3, input logic [7:0] i4, input logic [7:0] m,
                            input int exp_cyc, input bit with_req, input bit poke);
        int n;
        @(negedge clk); #1;
        icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4; ocw1_mask = m;
        base_wr   = wr_pulses;
        start     = 1'b1;
        req_valid = with_req;
        req_rd    = 1'b0; req_a0 = 1'b1; req_data = 8'hA5;
        #1;
        if (with_req) check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        @(negedge clk); #1;
        start = 1'b0; req_valid = 1'b0;
        check({tag, "_setup"}, {31'd0, CS_n}, 32'd0);
        n = 0;
        while (!init_done && n < 200) begin
            @(negedge clk); #1;
            n++;
            start = (poke && n == 10);
        end
        start = 1'b0;
        check({tag, "_cycles"}, n, exp_cyc);
    endtask

    // Issue one controller request and wait for the bus to go quiet
    task automatic do_req(input string tag, input logic rd, input logic a0, input logic [7:0] d);
        int n;
        @(negedge clk); #1;
        req_valid = 1'b1; req_rd = rd; req_a0 = a0; req_data = d;
        #1;
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        @(negedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check({tag, "_done"}, {31'd0, busy}, 32'd0);
    endtask

    logic [8:0] exp5 [0:4];
    int b_oe, b_rd, b_rdv, b_recov, n;

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_cs_n", {31'd0, CS_n}, 32'd1);
        check("rst_wr_rd", {30'd0, WR_n, RD_n}, 32'd3);
        check("rst_pins", {22'd0, A0, D_oe, D_out}, 32'd0);
        check("rst_status", {20'd0, rd_data, rd_valid, busy, init_done, req_ready}, 32'd0);
        rst = 1'b0;

        // Test 1: full sequence with cascade and ICW4, plus an ignored start mid-init
        run_init("init1", 8'h11, 8'h08, 8'h04, 8'h01, 8'hFF, 30, 1'b0, 1'b1);
        check("init1_pulses", wr_pulses - base_wr, 5);
        exp5 = '{9'h011, 9'h108, 9'h104, 9'h101, 9'h1FF};
        for (int i = 0; i < 5; i++) check($sformatf("init1_w%0d", i), wr_log[base_wr + i], exp5[i]);
        check("init1_busy", {31'd0, busy}, 32'd0);
        check("init1_ready", {31'd0, req_ready}, 32'd1);

        // Test 2: single mode, no ICW4, ICW1 tag bit forced
        run_init("init2", 8'h02, 8'h20, 8'h77, 8'h66, 8'h3C, 18, 1'b0, 1'b0);
        check("init2_pulses", wr_pulses - base_wr, 3);
        exp5 = '{9'h012, 9'h120, 9'h13C, 9'h000, 9'h000};
        for (int i = 0; i < 3; i++) check($sformatf("init2_w%0d", i), wr_log[base_wr + i], exp5[i]);

        // Test 3: command-port write clears bit4, timing of strobe/select/OE
        base_wr = wr_pulses; b_oe = oe_cycles; b_recov = recov_oe;
        do_req("wr", 1'b0, 1'b0, 8'h1A);
        check("wr_pulses", wr_pulses - base_wr, 1);
        check("wr_pins", wr_log[base_wr], 9'h00A);
        check("wr_len", last_wr_len, 2);
        check("wr_cs_len", last_cs_len, 4);
        check("wr_oe_cycles", oe_cycles - b_oe, 4);
        check("wr_recov_oe", recov_oe - b_recov, 0);

        // Test 4: register read with the PIC model on D_in
        base_wr = wr_pulses; b_oe = oe_cycles; b_rd = rd_pulses; b_rdv = rdv_pulses;
        do_req("rd", 1'b1, 1'b0, 8'h00);
        check("rd_pulses", rd_pulses - b_rd, 1);
        check("rd_len", last_rd_len, 2);
        check("rd_cs_len", last_cs_len, 4);
        check("rd_oe", oe_cycles - b_oe, 0);
        check("rd_no_wr", wr_pulses - base_wr, 0);
        check("rd_valid_cnt", rdv_pulses - b_rdv, 1);
        check("rd_valid_data", rdv_data, 8'h5C);
        check("rd_data_hold", rd_data, 8'h5C);

        // Test 5: start and request together -> start wins, request dropped
        run_init("both", 8'h11, 8'h08, 8'h04, 8'h01, 8'hFF, 30, 1'b1, 1'b0);
        check("both_pulses", wr_pulses - base_wr, 5);
        check("both_first", wr_log[base_wr], 9'h011);

        // Test 6: async reset during ICW2 strobe, then restart from ICW1
        @(negedge clk); #1;
        icw1 = 8'h11; icw2 = 8'h08; icw3 = 8'h04; icw4 = 8'h01; ocw1_mask = 8'hFF;
        base_wr = wr_pulses;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        n = 0;
        while (wr_pulses < base_wr + 2 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("rst_mid_wr_low", {30'd0, WR_n, A0}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_strobes", {29'd0, WR_n, CS_n, D_oe}, 32'd6);
        check("rst_mid_status", {30'd0, busy, init_done}, 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        run_init("reinit", 8'h11, 8'h08, 8'h04, 8'h01, 8'hFF, 30, 1'b0, 1'b0);
        check("reinit_first", wr_log[base_wr], 9'h011);
        check("reinit_pulses", wr_pulses - base_wr, 5);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
